// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared types and defaults for the pipeline hazard controller
// Contents: ctrl_state_t (RUN/DRAIN/RELEASE), default drain depth and counter width.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        RELEASE = 2'd2
    } ctrl_state_t;

    // Bubbles inserted behind sync: one each for EX, MEM and WB.
    localparam int DRAIN_DEPTH_DEF = 3;
    localparam int CNT_W_DEF       = 2;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - hazard request / pipeline control bundle
// master: pipeline side, drives the hazard requests and consumes the controls.
// slave : hazard controller, consumes the requests and drives the controls.
// Optional perf counter outputs exist only with PIPE_CTRL_PERF_EN defined.
interface pipe_hazard_ctrl_if;

    logic insert_bubble;
    logic id_is_sync;
    logic ex_branch_taken;
    logic mem_busy;
    logic store_buf_empty;

    logic pc_hold;
    logic if_id_hold;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_hold;
    logic is_stalling;
    logic sync_active;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_flush_count;

    modport master (
        output insert_bubble, id_is_sync, ex_branch_taken, mem_busy, store_buf_empty,
        input  pc_hold, if_id_hold, if_id_flush, id_ex_flush, ex_mem_hold,
        input  is_stalling, sync_active, perf_stall_cycles, perf_flush_count
    );

    modport slave (
        input  insert_bubble, id_is_sync, ex_branch_taken, mem_busy, store_buf_empty,
        output pc_hold, if_id_hold, if_id_flush, id_ex_flush, ex_mem_hold,
        output is_stalling, sync_active, perf_stall_cycles, perf_flush_count
    );
`else
    modport master (
        output insert_bubble, id_is_sync, ex_branch_taken, mem_busy, store_buf_empty,
        input  pc_hold, if_id_hold, if_id_flush, id_ex_flush, ex_mem_hold,
        input  is_stalling, sync_active
    );

    modport slave (
        input  insert_bubble, id_is_sync, ex_branch_taken, mem_busy, store_buf_empty,
        output pc_hold, if_id_hold, if_id_flush, id_ex_flush, ex_mem_hold,
        output is_stalling, sync_active
    );
`endif

endinterface

// File: rtl/pipe_perf_cnt.sv
// rtl/pipe_perf_cnt.sv - stall-cycle and flush-cycle performance counters
// Ports: clk, rst_n (sync, active-low), i_stall (pc_hold this cycle),
//        i_flush (if_id_flush this cycle), o_stall_cycles, o_flush_count (32-bit, wrapping).
module pipe_perf_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_stall,
    input  logic        i_flush,
    output logic [31:0] o_stall_cycles,
    output logic [31:0] o_flush_count
);

    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;

    // The reset branch keeps the reset-time flush from being counted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (i_stall) r_stall_cycles <= r_stall_cycles + 32'd1;
            if (i_flush) r_flush_count  <= r_flush_count + 32'd1;
        end
    end

    assign o_stall_cycles = r_stall_cycles;
    assign o_flush_count  = r_flush_count;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the five-stage pipeline
// Ports: sys_clk (rising edge), rst_n (sync, active-low), ctl (pipe_hazard_ctrl_if.slave):
//   requests insert_bubble, id_is_sync, ex_branch_taken, mem_busy, store_buf_empty;
//   controls pc_hold, if_id_hold, if_id_flush, id_ex_flush, ex_mem_hold, is_stalling,
//   sync_active. Parameters DRAIN_DEPTH, CNT_W (2**CNT_W must exceed DRAIN_DEPTH).
// Optional: PIPE_CTRL_PERF_EN adds perf_stall_cycles / perf_flush_count via pipe_perf_cnt.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int DRAIN_DEPTH = DRAIN_DEPTH_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    pipe_hazard_ctrl_if.slave ctl
);

    localparam logic [CNT_W-1:0] LP_DEPTH = CNT_W'(DRAIN_DEPTH);
    localparam logic [CNT_W-1:0] LP_ONE   = CNT_W'(1);

    ctrl_state_t      r_state;
    ctrl_state_t      w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_dec;

    logic w_pc_hold;
    logic w_if_id_hold;
    logic w_if_id_flush;
    logic w_id_ex_flush;
    logic w_ex_mem_hold;
    logic w_is_stalling;

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign w_cnt_dec = (r_cnt == '0) ? '0 : (r_cnt - LP_ONE);

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_pc_hold     = 1'b0;
        w_if_id_hold  = 1'b0;
        w_if_id_flush = 1'b0;
        w_id_ex_flush = 1'b0;
        w_ex_mem_hold = 1'b0;
        w_is_stalling = 1'b0;

        if (!rst_n) begin
            // Load NOPs into the front registers while reset is held.
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
        end else if (ctl.mem_busy) begin
            // Whole-pipeline freeze; a taken branch waits in the held EX stage.
            w_pc_hold     = 1'b1;
            w_if_id_hold  = 1'b1;
            w_ex_mem_hold = 1'b1;
            w_is_stalling = 1'b1;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (ctl.ex_branch_taken) begin
                        // Younger instructions are killed, so bubble/sync requests are moot.
                        w_if_id_flush = 1'b1;
                        w_id_ex_flush = 1'b1;
                    end else if (ctl.id_is_sync) begin
                        w_pc_hold     = 1'b1;
                        w_if_id_hold  = 1'b1;
                        w_id_ex_flush = 1'b1;
                        w_state_nxt   = DRAIN;
                        w_cnt_nxt     = LP_DEPTH;
                    end else if (ctl.insert_bubble) begin
                        w_pc_hold     = 1'b1;
                        w_if_id_hold  = 1'b1;
                        w_id_ex_flush = 1'b1;
                    end
                end
                DRAIN: begin
                    if (ctl.ex_branch_taken) begin
                        w_if_id_flush = 1'b1;
                        w_id_ex_flush = 1'b1;
                        w_cnt_nxt     = '0;
                        w_state_nxt   = RUN;
                    end else begin
                        w_pc_hold     = 1'b1;
                        w_if_id_hold  = 1'b1;
                        w_id_ex_flush = 1'b1;
                        w_cnt_nxt     = w_cnt_dec;
                        // Exit is judged on the post-decrement count so the last
                        // bubble cycle and the exit decision coincide.
                        if ((w_cnt_dec == '0) && ctl.store_buf_empty) begin
                            w_state_nxt = RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    // sync moves into EX; id_is_sync is deliberately ignored here.
                    w_state_nxt = RUN;
                end
                default: begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign ctl.pc_hold     = w_pc_hold;
    assign ctl.if_id_hold  = w_if_id_hold;
    assign ctl.if_id_flush = w_if_id_flush;
    assign ctl.id_ex_flush = w_id_ex_flush;
    assign ctl.ex_mem_hold = w_ex_mem_hold;
    assign ctl.is_stalling = w_is_stalling;
    assign ctl.sync_active = (r_state != RUN);

`ifdef PIPE_CTRL_PERF_EN
    pipe_perf_cnt u_perf (
        .clk            (sys_clk),
        .rst_n          (rst_n),
        .i_stall        (w_pc_hold),
        .i_flush        (w_if_id_flush),
        .o_stall_cycles (ctl.perf_stall_cycles),
        .o_flush_count  (ctl.perf_flush_count)
    );
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    localparam int DEPTH = 3;

    logic sys_clk = 1'b0;
    logic rst_n   = 1'b0;
    int   total   = 0;
    int   bad     = 0;
    bit   chk_en  = 1'b0;

    always #5 sys_clk = ~sys_clk;

    pipe_hazard_ctrl_if ctl ();

    pipe_hazard_ctrl #(.DRAIN_DEPTH(DEPTH), .CNT_W(2)) dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .ctl     (ctl)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 = normal running, 1 = waiting out the sync drain, 2 = sync release.
    int m_phase = 0;
    int m_left  = 0;
    int m_stall = 0;
    int m_flush = 0;

    // Returns {pc_hold, if_id_hold, if_id_flush, id_ex_flush, ex_mem_hold, is_stalling, sync_active}.
    function automatic logic [6:0] expect_out(input int ph, input logic rn, input logic ib,
                                              input logic sy, input logic br, input logic mb);
        logic sa;
        sa = (ph != 0);
        if (!rn)           return {6'b001100, sa};
        if (mb)            return {6'b110011, sa};
        if (ph == 2)       return {6'b000000, sa};
        if (br)            return {6'b001100, sa};
        if (ph == 1 || sy || ib) return {6'b110100, sa};
        return {6'b000000, sa};
    endfunction

    always @(posedge sys_clk) begin
        logic [6:0] e;
        int nl;
        e = expect_out(m_phase, rst_n, ctl.insert_bubble, ctl.id_is_sync,
                       ctl.ex_branch_taken, ctl.mem_busy);
        if (!rst_n) begin
            m_phase <= 0;
            m_left  <= 0;
            m_stall <= 0;
            m_flush <= 0;
        end else begin
            if (e[6]) m_stall <= m_stall + 1;
            if (e[4]) m_flush <= m_flush + 1;
            if (!ctl.mem_busy) begin
                if (m_phase == 0) begin
                    if (!ctl.ex_branch_taken && ctl.id_is_sync) begin
                        m_phase <= 1;
                        m_left  <= DEPTH;
                    end
                end else if (m_phase == 1) begin
                    if (ctl.ex_branch_taken) begin
                        m_phase <= 0;
                        m_left  <= 0;
                    end else begin
                        nl = (m_left > 0) ? m_left - 1 : 0;
                        m_left <= nl;
                        if (nl == 0 && ctl.store_buf_empty) m_phase <= 2;
                    end
                end else begin
                    m_phase <= 0;
                end
            end
        end
    end

    always @(negedge sys_clk) begin
        logic [6:0] e;
        if (chk_en) begin
            e = expect_out(m_phase, rst_n, ctl.insert_bubble, ctl.id_is_sync,
                           ctl.ex_branch_taken, ctl.mem_busy);
            chk("cyc_pc_hold",     {31'd0, ctl.pc_hold},     {31'd0, e[6]});
            chk("cyc_if_id_hold",  {31'd0, ctl.if_id_hold},  {31'd0, e[5]});
            chk("cyc_if_id_flush", {31'd0, ctl.if_id_flush}, {31'd0, e[4]});
            chk("cyc_id_ex_flush", {31'd0, ctl.id_ex_flush}, {31'd0, e[3]});
            chk("cyc_ex_mem_hold", {31'd0, ctl.ex_mem_hold}, {31'd0, e[2]});
            chk("cyc_is_stalling", {31'd0, ctl.is_stalling}, {31'd0, e[1]});
            chk("cyc_sync_active", {31'd0, ctl.sync_active}, {31'd0, e[0]});
`ifdef PIPE_CTRL_PERF_EN
            chk("cyc_perf_stall", ctl.perf_stall_cycles, m_stall);
            chk("cyc_perf_flush", ctl.perf_flush_count, m_flush);
`endif
        end
    end

    // Drive one cycle of inputs just after the rising edge; return at the falling edge.
    task automatic apply(input logic rn, input logic ib, input logic sy,
                         input logic br, input logic mb, input logic sbe);
        @(posedge sys_clk);
        #1;
        rst_n               = rn;
        ctl.insert_bubble   = ib;
        ctl.id_is_sync      = sy;
        ctl.ex_branch_taken = br;
        ctl.mem_busy        = mb;
        ctl.store_buf_empty = sbe;
        @(negedge sys_clk);
    endtask

    initial begin
        logic [5:0]  v6_pc, v6_sa;
        logic [8:0]  v9_pc, v9_sa;
        logic [10:0] v11_pc, v11_sa, v11_st, v11_fl;

        ctl.insert_bubble   = 1'b0;
        ctl.id_is_sync      = 1'b0;
        ctl.ex_branch_taken = 1'b0;
        ctl.mem_busy        = 1'b0;
        ctl.store_buf_empty = 1'b1;
        chk_en = 1'b1;

        // Reset
        apply(0, 0, 0, 0, 0, 1);
        apply(0, 0, 0, 0, 0, 1);
        chk("rst_if_id_flush", {31'd0, ctl.if_id_flush}, 32'd1);
        chk("rst_id_ex_flush", {31'd0, ctl.id_ex_flush}, 32'd1);
        chk("rst_pc_hold",     {31'd0, ctl.pc_hold},     32'd0);
        chk("rst_sync_active", {31'd0, ctl.sync_active}, 32'd0);
`ifdef PIPE_CTRL_PERF_EN
        chk("rst_perf_stall", ctl.perf_stall_cycles, 32'd0);
        chk("rst_perf_flush", ctl.perf_flush_count, 32'd0);
`endif
        apply(1, 0, 0, 0, 0, 1);
        chk("idle_if_id_flush", {31'd0, ctl.if_id_flush}, 32'd0);

        // Load-use bubble, one cycle only
        apply(1, 1, 0, 0, 0, 1);
        chk("lu_pc_hold",     {31'd0, ctl.pc_hold},     32'd1);
        chk("lu_id_ex_flush", {31'd0, ctl.id_ex_flush}, 32'd1);
        apply(1, 0, 0, 0, 0, 1);
        chk("lu_after_pc_hold", {31'd0, ctl.pc_hold},     32'd0);
        chk("lu_sync_active",   {31'd0, ctl.sync_active}, 32'd0);

        // Branch beats bubble
        apply(1, 1, 0, 1, 0, 1);
        chk("br_if_id_flush", {31'd0, ctl.if_id_flush}, 32'd1);
        chk("br_id_ex_flush", {31'd0, ctl.id_ex_flush}, 32'd1);
        chk("br_pc_hold",     {31'd0, ctl.pc_hold},     32'd0);

        // Sync, stores empty: sync held in ID through RELEASE, must not re-trigger
        v6_pc = 6'b001111;
        v6_sa = 6'b011110;
        for (int i = 0; i < 6; i++) begin
            apply(1, 0, (i < 5), 0, 0, 1);
            chk("sync_pc_hold",     {31'd0, ctl.pc_hold},     {31'd0, v6_pc[i]});
            chk("sync_sync_active", {31'd0, ctl.sync_active}, {31'd0, v6_sa[i]});
        end

        // Sync, stores pending until cycle 6
        v9_pc = 9'b001111111;
        v9_sa = 9'b011111110;
        for (int i = 0; i < 9; i++) begin
            apply(1, 0, (i <= 7), 0, 0, (i >= 6));
            chk("sbuf_pc_hold",     {31'd0, ctl.pc_hold},     {31'd0, v9_pc[i]});
            chk("sbuf_sync_active", {31'd0, ctl.sync_active}, {31'd0, v9_sa[i]});
        end

        // Freeze for 5 cycles with counter at 2
        v11_pc = 11'b00111111111;
        v11_sa = 11'b01111111110;
        v11_st = 11'b00001111100;
        v11_fl = 11'b00110000011;
        for (int i = 0; i < 11; i++) begin
            apply(1, 0, (i <= 9), 0, (i >= 2 && i <= 6), 1);
            chk("frz_pc_hold",     {31'd0, ctl.pc_hold},     {31'd0, v11_pc[i]});
            chk("frz_sync_active", {31'd0, ctl.sync_active}, {31'd0, v11_sa[i]});
            chk("frz_is_stalling", {31'd0, ctl.is_stalling}, {31'd0, v11_st[i]});
            chk("frz_id_ex_flush", {31'd0, ctl.id_ex_flush}, {31'd0, v11_fl[i]});
        end

        // Branch held behind a freeze, acted on once unfrozen
        apply(1, 0, 0, 1, 1, 1);
        chk("frzbr_if_id_flush", {31'd0, ctl.if_id_flush}, 32'd0);
        chk("frzbr_ex_mem_hold", {31'd0, ctl.ex_mem_hold}, 32'd1);
        apply(1, 0, 0, 1, 0, 1);
        chk("frzbr_after_flush", {31'd0, ctl.if_id_flush}, 32'd1);

        // Branch during DRAIN
        apply(1, 0, 1, 0, 0, 1);
        apply(1, 0, 1, 0, 0, 1);
        apply(1, 0, 1, 1, 0, 1);
        chk("drbr_if_id_flush", {31'd0, ctl.if_id_flush}, 32'd1);
        chk("drbr_pc_hold",     {31'd0, ctl.pc_hold},     32'd0);
        apply(1, 0, 0, 0, 0, 1);
        chk("drbr_sync_active", {31'd0, ctl.sync_active}, 32'd0);

        // Reset mid-DRAIN
        apply(1, 0, 1, 0, 0, 1);
        apply(1, 0, 1, 0, 0, 1);
        apply(0, 0, 1, 0, 0, 1);
        chk("rstd_if_id_flush", {31'd0, ctl.if_id_flush}, 32'd1);
        chk("rstd_id_ex_flush", {31'd0, ctl.id_ex_flush}, 32'd1);
        chk("rstd_pc_hold",     {31'd0, ctl.pc_hold},     32'd0);
        apply(1, 0, 0, 0, 0, 1);
        chk("rstd_sync_active", {31'd0, ctl.sync_active}, 32'd0);
`ifdef PIPE_CTRL_PERF_EN
        chk("rstd_perf_stall", ctl.perf_stall_cycles, 32'd0);
        chk("rstd_perf_flush", ctl.perf_flush_count, 32'd0);
`endif
        apply(1, 0, 0, 0, 0, 1);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
